// File: rtl/vga_stream_receiver.sv
// vga_stream_receiver: recovers pixel position and colour from a TinyVGA PMOD
// byte stream sampled on the pixel clock. It locks its own h/v counters to the
// incoming sync pulses and reports lock losses.
// Stream semantics: there is no backpressure. pix_valid qualifies pix_x/pix_y
// and the colours in the cycle they are presented; a new output appears every
// clock, exactly 2 clocks after the matching vga_in byte.
module vga_stream_receiver #(
  parameter int H_DISPLAY      = 640,
  parameter int H_SYNC_START   = 656,
  parameter int H_TOTAL        = 800,
  parameter int V_DISPLAY      = 480,
  parameter int V_SYNC_START   = 490,
  parameter int V_TOTAL        = 525,
  parameter int MIN_GOOD_LINES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] vga_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [1:0] pix_r,
  output logic [1:0] pix_g,
  output logic [1:0] pix_b,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    H_ALIGN = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [9:0] HD    = 10'(H_DISPLAY);
  localparam logic [9:0] HSS   = 10'(H_SYNC_START);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VD    = 10'(V_DISPLAY);
  localparam logic [9:0] VSS   = 10'(V_SYNC_START);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);
  localparam logic [3:0] MIN_GL = 4'(MIN_GOOD_LINES);

  state_t     state;
  state_t     state_next;
  logic [7:0] vga_q;
  logic       hs_prev;
  logic       vs_prev;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic [3:0] good_lines;

  logic       h_edge;
  logic       v_edge;
  logic       at_hsync;
  logic       at_vsync;
  logic       h_match;
  logic       v_match;
  logic       h_err;
  logic       v_err;
  logic       lock_err;
  logic       h_wrap;
  logic [9:0] hcnt_step;
  logic [9:0] vcnt_step;
  logic       realign;
  logic       vlock;
  logic       gl_inc;
  logic       load_valid;

  // Input capture: one register stage plus the previous sync levels for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_q   <= 8'd0;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vga_q   <= vga_in;
      hs_prev <= vga_q[7];
      vs_prev <= vga_q[3];
    end
  end

  // Syncs are active-low, so an edge is the high-to-low transition
  assign h_edge   = !vga_q[7] && hs_prev;
  assign v_edge   = !vga_q[3] && vs_prev;
  assign at_hsync = (hcnt == HSS);
  assign at_vsync = (hcnt == 10'd0) && (vcnt == VSS);
  assign h_match  = h_edge && at_hsync;
  assign v_match  = v_edge && at_vsync;
  // An expected edge that is missing counts the same as an unexpected one
  assign h_err    = (h_edge && !h_match) || (at_hsync && !h_edge);
  assign v_err    = (v_edge && !v_match) || (at_vsync && !v_edge);
  assign lock_err = (state == LOCKED) && (h_err || v_err);

  assign h_wrap    = (hcnt == HT_M1);
  assign hcnt_step = h_wrap ? 10'd0 : hcnt + 10'd1;
  assign vcnt_step = h_wrap ? ((vcnt == VT_M1) ? 10'd0 : vcnt + 10'd1) : vcnt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  // Next-state logic plus the counter realign/lock strobes it owns
  always_comb begin
    state_next = state;
    realign    = 1'b0;
    vlock      = 1'b0;
    gl_inc     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (h_edge) begin
          realign    = 1'b1;
          state_next = H_ALIGN;
        end
      end
      H_ALIGN: begin
        if (h_match)     gl_inc  = 1'b1;
        else if (h_edge) realign = 1'b1;
        if (v_edge && (hcnt == 10'd0) && (good_lines >= MIN_GL)) begin
          vlock      = 1'b1;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err || v_err) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // Output decode of the FSM; an erroring cycle already blanks the output stage
  always_comb begin
    locked     = (state == LOCKED);
    fsm_state  = state;
    load_valid = (state == LOCKED) && !lock_err && (hcnt < HD) && (vcnt < VD);
  end

  // Position counters: free-running, overridden on realign (h) or lock (v)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= 10'd0;
      vcnt <= 10'd0;
    end else begin
      hcnt <= realign ? HSS + 10'd1 : hcnt_step;
      vcnt <= vlock ? VSS : vcnt_step;
    end
  end

  // Good-line counter (saturating) and lock-loss counter (saturating)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      good_lines <= 4'd0;
      err_count  <= 8'd0;
    end else begin
      if (realign)                           good_lines <= 4'd0;
      else if (gl_inc && good_lines != 4'hF) good_lines <= good_lines + 4'd1;
      if (lock_err && err_count != 8'hFF)    err_count  <= err_count + 8'd1;
    end
  end

  // Output stage: colours are forced to 0 outside valid pixels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_r       <= 2'd0;
      pix_g       <= 2'd0;
      pix_b       <= 2'd0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= load_valid;
      pix_x       <= hcnt;
      pix_y       <= vcnt;
      pix_r       <= load_valid ? {vga_q[0], vga_q[4]} : 2'd0;
      pix_g       <= load_valid ? {vga_q[1], vga_q[5]} : 2'd0;
      pix_b       <= load_valid ? {vga_q[2], vga_q[6]} : 2'd0;
      frame_start <= load_valid && (hcnt == 10'd0) && (vcnt == 10'd0);
    end
  end

endmodule
